// File: rtl/audio_tone_player.sv
// Audio peripheral: latches a note byte from the register-file bus and plays it
// as a square wave on the speaker pin for a programmed duration.
module audio_tone_player #(
  parameter int PRESCALE  = 50,
  parameter int DUR_TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audioreg,
  input  logic       audioact,
  input  logic [7:0] data_in,
  output logic       spk,
  output logic       busy,
  output logic       done,
  output logic [7:0] note_q
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(8 * DUR_TICKS + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t        state_r;
  logic [PW-1:0] pre_r;
  logic [4:0]    hp_r;
  logic [4:0]    hp_cnt_r;
  logic [2:0]    len_r;
  logic [DW-1:0] dur_cnt_r;

  logic          tick_s;
  logic          hp_hit_s;
  logic          note_end_s;
  logic [DW-1:0] dur_last_s;

  // Tick, half-period match and end-of-note decode from the working registers.
  always_comb begin
    tick_s     = (pre_r == PW'(PRESCALE - 1));
    hp_hit_s   = (hp_cnt_r == (hp_r - 5'd1));
    dur_last_s = DW'((int'(len_r) + 1) * DUR_TICKS - 1);
    note_end_s = tick_s && (dur_cnt_r == dur_last_s);
  end

  // Note register, play FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      note_q    <= 8'h00;
      spk       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pre_r     <= '0;
      hp_r      <= 5'd0;
      hp_cnt_r  <= 5'd0;
      len_r     <= 3'd0;
      dur_cnt_r <= '0;
    end else begin
      if (audioreg) begin
        note_q <= data_in;
      end
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          spk  <= 1'b0;
          busy <= 1'b0;
          if (audioact) begin
            // Working copy taken from the pre-edge register so a same-cycle load
            // only affects the next note.
            state_r   <= PLAY;
            busy      <= 1'b1;
            hp_r      <= note_q[4:0];
            len_r     <= note_q[7:5];
            pre_r     <= '0;
            hp_cnt_r  <= 5'd0;
            dur_cnt_r <= '0;
          end
        end
        PLAY: begin
          if (tick_s) begin
            pre_r     <= '0;
            dur_cnt_r <= dur_cnt_r + DW'(1);
            if (hp_r == 5'd0) begin
              spk <= 1'b0;
            end else if (hp_hit_s) begin
              spk      <= ~spk;
              hp_cnt_r <= 5'd0;
            end else begin
              hp_cnt_r <= hp_cnt_r + 5'd1;
            end
          end else begin
            pre_r <= pre_r + PW'(1);
          end
          if (note_end_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            spk     <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          spk     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_player.sv
// Scoreboard bench for audio_tone_player with PRESCALE=2, DUR_TICKS=4: stimulus
// queues expected note shapes, a negedge monitor measures each note and checks on done.
module tb_audio_tone_player;

  logic       clk;
  logic       reset;
  logic       audioreg;
  logic       audioact;
  logic [7:0] data_in;
  logic       spk;
  logic       busy;
  logic       done;
  logic [7:0] note_q;

  audio_tone_player #(.PRESCALE(2), .DUR_TICKS(4)) dut (
    .clk(clk), .reset(reset), .audioreg(audioreg), .audioact(audioact),
    .data_in(data_in), .spk(spk), .busy(busy), .done(done), .note_q(note_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int tog;
    int intv;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  int   cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_spk = 1'b0;
  int   blen, tog, badi, last, exp_int, inv_bad;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_busy = 1'b0;
      prev_spk  = 1'b0;
      inv_bad   = 0;
    end else begin
      if (busy && !prev_busy) begin
        blen    = 0;
        tog     = 0;
        badi    = 0;
        inv_bad = 0;
        last    = cyc;
        exp_int = (exp_q.size() > 0) ? exp_q[0].intv : 0;
      end
      if (busy) blen++;
      if ((done && busy) || (!busy && spk)) inv_bad++;
      if (spk != prev_spk) begin
        tog++;
        if (exp_int != 0 && (cyc - last) != exp_int) badi++;
        last = cyc;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", blen, e.len);
          check("toggles", tog, e.tog);
          check("toggle_interval_errs", badi, 0);
          check("done_follows_busy", int'(prev_busy), 1);
          check("spk_low_at_done", int'(spk), 0);
          check("invariant_errs", inv_bad, 0);
        end
        done_seen++;
      end
      prev_busy = busy;
      prev_spk  = spk;
    end
    cyc++;
  end

  task automatic load(input logic [7:0] d);
    @(posedge clk); #1;
    audioreg = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    audioreg = 1'b0;
  endtask

  task automatic play();
    @(posedge clk); #1;
    audioact = 1'b1;
    @(posedge clk); #1;
    audioact = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_seen < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_seen < n) check("done_timeout", done_seen, n);
  endtask

  initial begin
    reset    = 1'b0;
    audioreg = 1'b0;
    audioact = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_note_q", int'(note_q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_spk_done", int'({spk, done}), 0);
    reset = 1'b1;

    // Start a note, then abort it with reset mid-note.
    load(8'h22);
    play();
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", int'({note_q, spk, busy, done}), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_seen, 0);

    // Load after reset
    @(posedge clk); #1;
    audioreg = 1'b1;
    data_in  = 8'h22;
    @(posedge clk); #1;
    audioreg = 1'b0;
    @(negedge clk);
    check("load_note_q", int'(note_q), 8'h22);
    check("load_busy", int'(busy), 0);

    // Basic note 0x22: 16 clocks, toggles every 4.
    exp_q.push_back('{len: 16, tog: 4, intv: 4});
    play();
    wait_done(1);

    // Rest note 0x40: 24 clocks, no toggles.
    load(8'h40);
    exp_q.push_back('{len: 24, tog: 0, intv: 0});
    play();
    wait_done(2);

    // Retrigger + load during play are ignored by the running note.
    load(8'h22);
    exp_q.push_back('{len: 16, tog: 4, intv: 4});
    play();
    repeat (4) @(posedge clk);
    #1;
    audioact = 1'b1;
    audioreg = 1'b1;
    data_in  = 8'hE1;
    @(posedge clk); #1;
    audioact = 1'b0;
    audioreg = 1'b0;
    @(negedge clk);
    check("load_in_play", int'(note_q), 8'hE1);
    wait_done(3);
    repeat (30) @(negedge clk);
    check("no_retrigger_busy", int'(busy), 0);
    check("no_retrigger_done", done_seen, 3);

    // Simultaneous load + play uses the old value.
    load(8'h22);
    exp_q.push_back('{len: 16, tog: 4, intv: 4});
    @(posedge clk); #1;
    audioact = 1'b1;
    audioreg = 1'b1;
    data_in  = 8'h01;
    @(posedge clk); #1;
    audioact = 1'b0;
    audioreg = 1'b0;
    @(negedge clk);
    check("simul_note_q", int'(note_q), 8'h01);
    wait_done(4);

    // Back-to-back 0x01 notes: 8 clocks, toggles every 2.
    exp_q.push_back('{len: 8, tog: 4, intv: 2});
    play();
    wait_done(5);
    check("b2b_in_done_cycle", int'(done), 1);
    exp_q.push_back('{len: 8, tog: 4, intv: 2});
    audioact = 1'b1;
    @(posedge clk); #1;
    audioact = 1'b0;
    @(negedge clk);
    check("b2b_busy_next", int'(busy), 1);
    wait_done(6);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_tone_player.md
Name: audio_tone_player

Overview:
- Peripheral that responds to the control unit's audio strobes.
- `audioreg` latches a note byte from the register-file read bus into the audio register.
- `audioact` plays the latched note as a square wave on the speaker pin for a programmed duration.
- Reports `busy` and a one-cycle `done`, so firmware can poll or sequence notes.
- Sits beside the output-port bank, fed by the same `rd2` data bus.

Parameters:
- PRESCALE, 50, clk cycles per base tick (min 1)
- DUR_TICKS, 1000, base ticks per duration unit (min 1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- audioreg  in  1  load strobe from control unit, one cycle
- audioact  in  1  play strobe from control unit, one cycle
- data_in  in  8  register-file read data (rd2)
- spk  out  1  square-wave speaker output
- busy  out  1  high while a note plays
- done  out  1  one-cycle pulse when a note finishes
- note_q  out  8  current audio register contents (readback)

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `note_q`=0x00, `spk`=0, `busy`=0, `done`=0.
  - All counters are cleared and the FSM goes to IDLE.
  - Reset asserted mid-note aborts the note immediately; no `done` pulse is produced.
- Register format: `note_q[4:0]` = half-period HP in base ticks; `note_q[7:5]` = length L; duration = (L+1)*DUR_TICKS ticks.
- Load:
  - `audioreg` sampled high at an edge loads `note_q` <= `data_in` at that edge.
  - Loading is allowed in any state. A note in progress is unaffected, because HP and L are copied into working registers at play start.
- FSM states IDLE, PLAY:
  - IDLE -> PLAY when `audioact`=1 at an edge. At that edge:
    - copy HP and L from the `note_q` value held before the edge;
    - clear the prescaler, half-period and duration counters;
    - `busy`=1 and `spk`=0 from the next cycle.
  - If `audioreg` and `audioact` are high in the same cycle, play uses the OLD `note_q`; `note_q` takes the new value.
  - PLAY:
    - The prescaler counts 0..PRESCALE-1; a tick is asserted when it wraps.
    - On each tick, the half-period counter increments. When it equals HP-1, `spk` toggles and the counter clears. Hence `spk` toggles every HP*PRESCALE clocks.
    - HP=0 means rest: `spk` is held 0 for the whole duration.
    - On each tick, the duration counter increments. The tick that makes it equal (L+1)*DUR_TICKS ends the note.
    - PLAY -> IDLE on the ending tick's edge: `busy`=0, `spk`=0, `done`=1 for exactly one cycle.
  - `audioact` while in PLAY is ignored (no retrigger, no queueing).
  - `audioact` in the cycle when `done` is high is accepted normally (back-to-back notes).
- Total `busy` time = (L+1)*DUR_TICKS*PRESCALE clocks.
- Counter widths must hold (8)*DUR_TICKS without overflow, and must not wrap.
- `done` and `busy` are never high together.
- `spk`=0 whenever `busy`=0.

Test Plan:
- Reset and load:
  - Stimulus: assert `reset`=0 mid-note; release; `audioreg` with `data_in`=0x22.
  - Required: outputs zero immediately with no `done`; then `note_q`=0x22 one edge after the strobe; `busy` stays 0.
- Basic note (PRESCALE=2, DUR_TICKS=4, `note_q`=0x22 so L=1, HP=2):
  - Stimulus: `audioact` pulse.
  - Required: `busy` high 16 clocks; `spk` toggles every 4 clocks (4 toggles, ends low); `done` high on the 17th cycle for 1 cycle.
- Rest note:
  - Stimulus: `note_q`=0x40 (L=2, HP=0), then play.
  - Required: `busy` high 24 clocks; `spk` stays 0 throughout; single `done` pulse.
- Ignore retrigger and load during play:
  - Stimulus: `audioact` and `audioreg` (`data_in`=0xE1) asserted 5 clocks into the 0x22 note.
  - Required: note still lasts 16 clocks with 4-clock toggles; `note_q`=0xE1 after the load.
- Simultaneous load+play:
  - Stimulus: `note_q`=0x22; `audioreg`+`audioact` together with `data_in`=0x01.
  - Required: plays the 0x22 timing (16 clocks); `note_q`=0x01 afterwards.
- Back-to-back:
  - Stimulus: `audioact` in the `done` cycle.
  - Required: `busy` re-asserts the next cycle; second note has full length.
